trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: TrapCtrl

---
 rtl/trap_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / mret sequencer driving a single CSR write port
module trap_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_MASK = 32'hFFFFFFFC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  input  logic [3:0]      io_in_excType,
  input  logic [XLEN-1:0] io_in_pc,
  input  logic [XLEN-1:0] io_in_inst,
  input  logic            io_in_irq,
  input  logic [XLEN-1:0] io_csr_mstatus,
  input  logic [XLEN-1:0] io_csr_mtvec,
  input  logic [XLEN-1:0] io_csr_mepc,
  output logic            io_csr_wrEn,
  output logic [11:0]     io_csr_wrAddr,
  output logic [XLEN-1:0] io_csr_wrData,
  output logic            io_out_stall,
  output logic            io_out_flush,
  output logic            io_out_redirectValid,
  output logic [XLEN-1:0] io_out_redirectPc,
  output logic            io_out_busy
);

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, MRET_STATUS, REDIRECT
  } state_t;

  state_t state, state_next;
  logic [XLEN-1:0] pc_q, cause_q, tval_q, target_q;
  logic [XLEN-1:0] cause_d, tval_d, status_trap, status_mret;
  logic idle, sync_exc, irq_take, trap_accept, mret_accept;

  // Synchronous exceptions win over the interrupt, which in turn suppresses mret.
  always_comb begin
    idle        = (state == IDLE);
    sync_exc    = (io_in_excType != 4'd0) && (io_in_excType != 4'd4);
    irq_take    = io_in_irq && io_csr_mstatus[3];
    trap_accept = idle && !reset && io_in_valid && (sync_exc || irq_take);
    mret_accept = idle && !reset && io_in_valid && !sync_exc && !irq_take
                  && (io_in_excType == 4'd4);

    cause_d = {1'b1, (XLEN-1)'(11)};
    tval_d  = '0;
    if (sync_exc) begin
      case (io_in_excType)
        4'd2:    cause_d = XLEN'(11);
        4'd3:    cause_d = XLEN'(3);
        4'd5: begin
          cause_d = '0;
          tval_d  = io_in_pc;
        end
        default: begin
          cause_d = XLEN'(2);
          tval_d  = io_in_inst;
        end
      endcase
    end

    status_trap       = io_csr_mstatus;
    status_trap[7]    = io_csr_mstatus[3];
    status_trap[3]    = 1'b0;
    status_trap[12:11] = 2'b11;

    status_mret    = io_csr_mstatus;
    status_mret[3] = io_csr_mstatus[7];
    status_mret[7] = 1'b1;
  end

  always_comb begin
    state_next           = state;
    io_csr_wrEn          = 1'b0;
    io_csr_wrAddr        = 12'h000;
    io_csr_wrData        = '0;
    io_out_stall         = !idle;
    io_out_flush         = 1'b0;
    io_out_redirectValid = 1'b0;
    io_out_redirectPc    = '0;
    case (state)
      IDLE: begin
        if (trap_accept) begin
          io_out_flush = 1'b1;
          io_out_stall = 1'b1;
          state_next   = SAVE_EPC;
        end else if (mret_accept) begin
          io_out_flush = 1'b1;
          io_out_stall = 1'b1;
          state_next   = MRET_STATUS;
        end
      end
      SAVE_EPC: begin
        io_csr_wrEn   = 1'b1;
        io_csr_wrAddr = 12'h341;
        io_csr_wrData = pc_q;
        state_next    = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        io_csr_wrEn   = 1'b1;
        io_csr_wrAddr = 12'h342;
        io_csr_wrData = cause_q;
        state_next    = SAVE_TVAL;
      end
      SAVE_TVAL: begin
        io_csr_wrEn   = 1'b1;
        io_csr_wrAddr = 12'h343;
        io_csr_wrData = tval_q;
        state_next    = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        io_csr_wrEn   = 1'b1;
        io_csr_wrAddr = 12'h300;
        io_csr_wrData = status_trap;
        state_next    = REDIRECT;
      end
      MRET_STATUS: begin
        io_csr_wrEn   = 1'b1;
        io_csr_wrAddr = 12'h300;
        io_csr_wrData = status_mret;
        state_next    = REDIRECT;
      end
      REDIRECT: begin
        io_out_redirectValid = 1'b1;
        io_out_redirectPc    = target_q;
        state_next           = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset kills any in-flight CSR write or redirect in the same cycle.
    if (reset) begin
      io_csr_wrEn          = 1'b0;
      io_csr_wrAddr        = 12'h000;
      io_csr_wrData        = '0;
      io_out_stall         = 1'b0;
      io_out_flush         = 1'b0;
      io_out_redirectValid = 1'b0;
      io_out_redirectPc    = '0;
    end
  end

  assign io_out_busy = !idle && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state <= state_next;
      if (trap_accept || mret_accept) begin
        pc_q     <= io_in_pc;
        cause_q  <= cause_d;
        tval_q   <= tval_d;
        target_q <= trap_accept ? (io_csr_mtvec & MTVEC_MASK) : io_csr_mepc;
      end
      // The target is re-sampled as the status write goes out, so it tracks CSR updates.
      if (state == SAVE_STATUS) target_q <= io_csr_mtvec & MTVEC_MASK;
      if (state == MRET_STATUS) target_q <= io_csr_mepc;
    end
  end

endmodule
